// File: rtl/fir_tap_accumulator.sv
// Sequential tap accumulator driving the shared 16-bit prefix adder; emits one sample per NTAPS products.
// Optional saturation on signed overflow: define FIR_ACC_SAT_EN (default build wraps modulo 2^16).
module fir_tap_accumulator #(
  parameter int NTAPS = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             prod_valid,
  output logic             prod_ready,
  input  logic [15:0]      prod_data,
  output logic [15:0]      add_a,
  output logic [15:0]      add_b,
  input  logic [15:0]      add_sum,
  output logic             acc_valid,
  input  logic             acc_ready,
  output logic [15:0]      acc_data,
  output logic             acc_ovf,
  output logic [CNT_W-1:0] tap_cnt
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state_r, state_nxt_s;
  logic [15:0]      acc_r, acc_nxt_s, load_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic             ovf_r, ovf_nxt_s;
  logic             valid_r, ready_r;
  logic             accept_s, ovf_s, last_s;

  // Signed overflow of a + b -> s: operands agree in sign, result does not.
  function automatic logic signed_ovf(input logic [15:0] a, input logic [15:0] b,
                                      input logic [15:0] s);
    return (a[15] == b[15]) && (s[15] != a[15]);
  endfunction

  assign add_a      = acc_r;
  assign add_b      = prod_data;
  assign acc_data   = acc_r;
  assign acc_ovf    = ovf_r;
  assign tap_cnt    = cnt_r;
  assign acc_valid  = valid_r;
  assign prod_ready = ready_r;

  assign accept_s = prod_valid & ready_r;
  assign ovf_s    = signed_ovf(add_a, add_b, add_sum);
  // cnt_r is 0 in IDLE, so the same compare covers the NTAPS==1 IDLE->DONE case.
  assign last_s   = (cnt_r == CNT_W'(NTAPS - 1));

  // Value loaded into the accumulator on an accepted product.
  always_comb begin
    load_s = add_sum;
`ifdef FIR_ACC_SAT_EN
    if (ovf_s) begin
      load_s = add_a[15] ? 16'h8000 : 16'h7FFF;
    end else begin
      load_s = add_sum;
    end
`endif
  end

  // Next-state logic; flush dominates every other condition.
  always_comb begin
    state_nxt_s = state_r;
    acc_nxt_s   = acc_r;
    cnt_nxt_s   = cnt_r;
    ovf_nxt_s   = ovf_r;
    if (flush) begin
      state_nxt_s = IDLE;
      acc_nxt_s   = 16'h0000;
      cnt_nxt_s   = {CNT_W{1'b0}};
      ovf_nxt_s   = 1'b0;
    end else begin
      case (state_r)
        IDLE, ACCUM: begin
          if (accept_s) begin
            acc_nxt_s   = load_s;
            cnt_nxt_s   = cnt_r + CNT_W'(1);
            ovf_nxt_s   = ovf_r | ovf_s;
            state_nxt_s = last_s ? DONE : ACCUM;
          end else begin
            state_nxt_s = state_r;
          end
        end
        DONE: begin
          if (acc_ready) begin
            state_nxt_s = IDLE;
            acc_nxt_s   = 16'h0000;
            cnt_nxt_s   = {CNT_W{1'b0}};
            ovf_nxt_s   = 1'b0;
          end else begin
            state_nxt_s = DONE;
          end
        end
        default: begin
          state_nxt_s = IDLE;
          acc_nxt_s   = 16'h0000;
          cnt_nxt_s   = {CNT_W{1'b0}};
          ovf_nxt_s   = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers; handshake flags are registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      acc_r   <= 16'h0000;
      cnt_r   <= {CNT_W{1'b0}};
      ovf_r   <= 1'b0;
      valid_r <= 1'b0;
      ready_r <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      acc_r   <= acc_nxt_s;
      cnt_r   <= cnt_nxt_s;
      ovf_r   <= ovf_nxt_s;
      valid_r <= (state_nxt_s == DONE);
      ready_r <= (state_nxt_s != DONE);
    end
  end

endmodule
